uart_tx_serializer: RTL

- Transmit side of the UART link; the counterpart to the receiver's deserializer/sampler chain.
- Accepts a parallel byte with a single-cycle valid strobe and emits one frame, one bit per CLK: start, 8 data bits LSB first, optional parity, stop.
- CLK is the TX bit clock, already divided to the baud rate upstream, so no oversampling is done here.
- Output drives the serial line directly and reports busy back to the system controller.

---
 rtl/uart_tx_serializer.sv | 96 +++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: turns a parallel word into a UART frame, one bit per CLK.
// The frame is start, data LSB first, optional parity, then stop; TX_OUT and busy are registered.
module uart_tx_serializer #(
   parameter int Data_width = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [Data_width-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic                  TX_OUT,
   output logic                  busy
);
   localparam int CW = (Data_width > 1) ? $clog2(Data_width) : 1;
   localparam logic [CW-1:0] LAST = CW'(Data_width - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [Data_width-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   // Outputs are decoded from the state being entered, so they line up with it.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      tx_d     = 1'b1;
      busy_d   = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (Data_Valid) begin
               data_d   = P_DATA;
               par_en_d = PAR_EN;
               par_d    = (^P_DATA) ^ PAR_TYP;
               state_d  = START;
               tx_d     = 1'b0;
               busy_d   = 1'b1;
            end
         end
         START: begin
            state_d = DATA;
            cnt_d   = '0;
            tx_d    = data_q[0];
            busy_d  = 1'b1;
         end
         DATA: begin
            busy_d = 1'b1;
            if (cnt_q == LAST) begin
               state_d = par_en_q ? PARITY : STOP;
               tx_d    = par_en_q ? par_q : 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               tx_d  = data_q[cnt_d];
            end
         end
         PARITY: begin
            state_d = STOP;
            busy_d  = 1'b1;
         end
         STOP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;
endmodule
